// File: rtl/wb_ram_slave.sv
// Wishbone B.3 slave RAM with programmable wait states, registered-feedback bursts
// (linear/wrap4/8/16) and ERR for accesses outside the address window. Requires AW_WORDS >= 4.
module wb_ram_slave #(
    parameter int          AW_WORDS    = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [29:0] ADR_I,
    input  logic [31:0] DAT_I,
    input  logic [3:0]  SEL_I,
    input  logic [2:0]  CTI_I,
    input  logic [1:0]  BTE_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic        RTY_O
);

    localparam int          DEPTH       = 1 << AW_WORDS;
    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_END     = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_BURST} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                ack_q;
    logic                err_q;
    logic [31:0]         dat_q;
    // One extra bit so a linear burst running off the top of the window is detectable.
    logic [AW_WORDS:0]   cur_off;
    logic [31:0]         mem [0:DEPTH-1];

    logic [29:0]         req_off;
    logic                req_in_range;
    logic [AW_WORDS-1:0] idx;
    logic                beat_en;
    logic                wr_en;

    function automatic logic [AW_WORDS:0] next_off(input logic [AW_WORDS:0] off,
                                                   input logic [1:0]        bte);
        logic [AW_WORDS:0] n;
        n = off;
        case (bte)
            2'b00:   n      = off + (AW_WORDS+1)'(1);
            2'b01:   n[1:0] = off[1:0] + 2'd1;
            2'b10:   n[2:0] = off[2:0] + 3'd1;
            default: n[3:0] = off[3:0] + 4'd1;
        endcase
        return n;
    endfunction

    assign req_off      = ADR_I - BASE_ADDR[31:2];
    assign req_in_range = (req_off[29:AW_WORDS] == '0);
    assign idx          = cur_off[AW_WORDS-1:0];

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        beat_en = 1'b0;
        if (!RST_I && CYC_I && STB_I) begin
            case (state)
                S_XFER:  beat_en = 1'b1;
                S_BURST: beat_en = !cur_off[AW_WORDS];
                default: beat_en = 1'b0;
            endcase
        end
    end

    assign wr_en = beat_en && WE_I;

    // NOTE: the memory array has no reset; contents survive RST_I and map onto RAM primitives.
    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (SEL_I[b]) mem[idx][8*b +: 8] <= DAT_I[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            cur_off <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (!CYC_I) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // A response still on the bus means the master has not yet retired it.
                        if (STB_I && !ack_q && !err_q) begin
                            if (!req_in_range) begin
                                err_q <= 1'b1;
                            end else begin
                                cur_off <= {1'b0, req_off[AW_WORDS-1:0]};
                                cnt     <= 4'(WAIT_STATES);
                                state   <= (WAIT_STATES == 0) ? S_XFER : S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (cnt <= 4'd1) begin
                            cnt   <= '0;
                            state <= S_XFER;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_XFER: begin
                        if (STB_I) begin
                            ack_q <= 1'b1;
                            if (!WE_I) dat_q <= mem[idx];
                            if (CTI_I == CTI_INCR) begin
                                state   <= S_BURST;
                                cur_off <= next_off(cur_off, BTE_I);
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_BURST: begin
                        if (STB_I) begin
                            if (cur_off[AW_WORDS]) begin
                                err_q <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                ack_q   <= 1'b1;
                                if (!WE_I) dat_q <= mem[idx];
                                cur_off <= next_off(cur_off, BTE_I);
                                if (CTI_I == CTI_END || CTI_I == CTI_CLASSIC) state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign DAT_O = dat_q;
    assign ACK_O = ack_q;
    assign ERR_O = err_q;
    assign RTY_O = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: a bench-side memory model feeds a queue of expected
// read data that is popped as the slave acknowledges each beat.
module tb_wb_ram_slave;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          WS   = 1;
    localparam logic [29:0] BW   = 30'h400;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_r;
    logic        ack, err, rty;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [0:(1<<AW)-1];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    wb_ram_slave #(.AW_WORDS(AW), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .DAT_I(dat_w), .SEL_I(sel), .CTI_I(cti), .BTE_I(bte),
        .DAT_O(dat_r), .ACK_O(ack), .ERR_O(err), .RTY_O(rty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
        dat_w = '0; sel = '0; cti = 3'b000; bte = 2'b00;
    endtask

    // Count edges until ACK or ERR shows up, sampling 1 time unit after each rising edge.
    task automatic wait_resp(output int lat, output bit timeout);
        lat = 0;
        timeout = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack || err) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic classic(input string tag, input bit w, input logic [29:0] a,
                           input logic [31:0] d, input logic [3:0] s, input bit exp_err);
        int              lat;
        bit              to;
        logic [31:0]     e;
        logic [AW-1:0]   ix;
        ix = AW'(a - BW);
        if (!w && !exp_err) exp_q.push_back(model[ix]);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
        wait_resp(lat, to);
        check({tag, " timeout"}, 32'(to), 32'(0));
        check({tag, " ack"}, 32'(ack), 32'(!exp_err));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " latency"}, 32'(lat), 32'(exp_err ? 1 : WS + 2));
        if (!w && !exp_err) begin
            e = exp_q.pop_front();
            check({tag, " data"}, dat_r, e);
        end
        if (w && !exp_err && ack) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[ix][8*b +: 8] = d[8*b +: 8];
        end
        bus_idle();
        @(posedge clk); #1;
        check({tag, " single cycle"}, {30'b0, ack, err}, 32'(0));
    endtask

    task automatic burst_read(input string tag, input logic [29:0] a, input logic [1:0] b, input int n);
        int            lat;
        bit            to;
        int            m;
        logic [AW-1:0] o;
        logic [AW-1:0] mask;
        logic [31:0]   e;
        m    = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : (b == 2'b11) ? 16 : 0;
        mask = AW'(m - 1);
        o    = AW'(a - BW);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model[o]);
            if (m == 0) o = o + 1'b1;
            else        o = (o & ~mask) | ((o + 1'b1) & mask);
        end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; cti = 3'b010; bte = b;
        wait_resp(lat, to);
        check({tag, " timeout"}, 32'(to), 32'(0));
        check({tag, " latency"}, 32'(lat), 32'(WS + 2));
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check({tag, " beat ack"}, 32'(ack), 32'(1));
            e = exp_q.pop_front();
            check({tag, " beat data"}, dat_r, e);
            adr = ~a;
            if (k == n - 2) cti = 3'b111;
        end
        bus_idle();
        @(posedge clk); #1;
        check({tag, " idle after last"}, {30'b0, ack, err}, 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        bit          to;
        logic [31:0] e;

        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset ack", 32'(ack), 32'(0));
        check("reset err", 32'(err), 32'(0));
        check("reset rty", 32'(rty), 32'(0));
        check("reset dat", dat_r, 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        classic("wr 0x10", 1'b1, BW + 30'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        classic("rd 0x10", 1'b0, BW + 30'h10, 32'h0, 4'hF, 1'b0);

        classic("wr 0x11 full", 1'b1, BW + 30'h11, 32'h1122_3344, 4'hF, 1'b0);
        classic("wr 0x11 byte1", 1'b1, BW + 30'h11, 32'h0000_AB00, 4'b0010, 1'b0);
        classic("rd 0x11", 1'b0, BW + 30'h11, 32'h0, 4'hF, 1'b0);
        check("byte merge model", model[11'h11], 32'h1122_AB44);

        for (int i = 0; i < 4; i++)
            classic("wr 0..3", 1'b1, BW + 30'(i), (i == 3) ? 32'h0 : 32'h100 + 32'(i), 4'hF, 1'b0);
        for (int i = 4; i < 8; i++)
            classic("wr 4..7", 1'b1, BW + 30'(i), 32'hA0 + 32'(i), 4'hF, 1'b0);
        burst_read("wrap4 from 6", BW + 30'd6, 2'b01, 4);

        classic("oor rd", 1'b0, BW + 30'd1024, 32'h0, 4'hF, 1'b1);
        classic("oor wr", 1'b1, BW + 30'd1024, 32'hBAD0_BAD0, 4'hF, 1'b1);
        classic("oor below", 1'b0, BW - 30'd1, 32'h0, 4'hF, 1'b1);
        classic("rd 0 after oor", 1'b0, BW, 32'h0, 4'hF, 1'b0);

        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BW + 30'd3; dat_w = 32'hFFFF_FFFF; sel = 4'hF;
        @(posedge clk); #1;
        check("cyc drop in wait", 32'(ack), 32'(0));
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("cyc drop no ack", {30'b0, ack, err}, 32'(0));
        end
        classic("rd 3 after drop", 1'b0, BW + 30'd3, 32'h0, 4'hF, 1'b0);

        classic("wr 1022", 1'b1, BW + 30'd1022, 32'hCAFE_0001, 4'hF, 1'b0);
        classic("wr 1023", 1'b1, BW + 30'd1023, 32'hCAFE_0002, 4'hF, 1'b0);
        exp_q.push_back(model[1022]);
        exp_q.push_back(model[1023]);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BW + 30'd1022; cti = 3'b010; bte = 2'b00;
        wait_resp(lat, to);
        check("lin exit timeout", 32'(to), 32'(0));
        check("lin exit beat1 ack", 32'(ack), 32'(1));
        e = exp_q.pop_front();
        check("lin exit beat1 data", dat_r, e);
        @(posedge clk); #1;
        check("lin exit beat2 ack", 32'(ack), 32'(1));
        e = exp_q.pop_front();
        check("lin exit beat2 data", dat_r, e);
        @(posedge clk); #1;
        check("lin exit err", {30'b0, ack, err}, 32'(1));
        bus_idle();
        @(posedge clk); #1;
        check("lin exit idle", {30'b0, ack, err}, 32'(0));

        exp_q.push_back(model[0]);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BW; cti = 3'b010; bte = 2'b00;
        wait_resp(lat, to);
        check("rst burst timeout", 32'(to), 32'(0));
        check("rst burst beat1 ack", 32'(ack), 32'(1));
        e = exp_q.pop_front();
        check("rst burst beat1 data", dat_r, e);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst burst ack", {30'b0, ack, err}, 32'(0));
        check("rst burst dat", dat_r, 32'(0));
        rst = 1'b0;
        bus_idle();
        @(posedge clk); #1;
        classic("rd 0 after rst", 1'b0, BW, 32'h0, 4'hF, 1'b0);

        check("scoreboard drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
